// File: rtl/skid_buffer_pkg.sv
// Shared handshake definitions: state encoding of the skid buffer and the
// width of its occupancy count.
package handshake_pkg;

  localparam int OCC_W = 2;

  // 2'b11 is deliberately left unused; the FSM recovers from it to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  // Number of beats held in a given state.
  function automatic logic [OCC_W-1:0] state_occupancy(input skid_state_t s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/skid_buffer_if.sv
// Valid/ready bundle around the skid buffer.
//
// Handshake: a beat moves across a link on a rising clk edge where both
// valid and ready are 1. A sender holding valid=1 keeps its data stable
// until that edge; ready may change freely and never depends on valid.
// The upstream link is data_in/valid_up_in/ready_up_out, the downstream
// link is data_out/valid_down_out/ready_down_in.
interface skid_buffer_if #(
  parameter int WIDTH = 32
);
  import handshake_pkg::*;

  logic [WIDTH-1:0] data_in;
  logic             valid_up_in;
  logic             ready_down_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_down_out;
  logic             ready_up_out;
  logic [OCC_W-1:0] occupancy;

  // Environment side: drives upstream beats and downstream ready.
  modport master (
    output data_in,
    output valid_up_in,
    output ready_down_in,
    input  data_out,
    input  valid_down_out,
    input  ready_up_out,
    input  occupancy
  );

  // Buffer side.
  modport slave (
    input  data_in,
    input  valid_up_in,
    input  ready_down_in,
    output data_out,
    output valid_down_out,
    output ready_up_out,
    output occupancy
  );

endinterface

// File: rtl/skid_buffer.sv
// Two-entry register slice. Forward (data, valid) and backward (ready)
// paths are both registered: every output decodes from the state flop and
// main_reg, so no input reaches an output combinationally. When downstream
// stalls while a beat is in flight, that beat is parked in skid_reg and
// delivered after main_reg, preserving FIFO order.
module skid_buffer
  import handshake_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  skid_buffer_if.slave bus,
  output skid_state_t state_dbg
);

  skid_state_t      state;
  skid_state_t      state_next;
  logic [WIDTH-1:0] main_reg;
  logic [WIDTH-1:0] skid_reg;

  logic             valid_down;
  logic             ready_up;
  logic [OCC_W-1:0] occ;

  logic             up_fire;
  logic             down_fire;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;

  // Output decode from the state flop only. The unused encoding reports
  // empty and refuses upstream beats so nothing is accepted and then lost
  // during recovery.
  always_comb begin
    valid_down = 1'b0;
    ready_up   = 1'b0;
    occ        = state_occupancy(state);
    case (state)
      EMPTY: begin
        ready_up = 1'b1;
      end
      BUSY: begin
        valid_down = 1'b1;
        ready_up   = 1'b1;
      end
      FULL: begin
        valid_down = 1'b1;
      end
      default: begin
        valid_down = 1'b0;
        ready_up   = 1'b0;
      end
    endcase
  end

  assign up_fire   = bus.valid_up_in & ready_up;
  assign down_fire = valid_down & bus.ready_down_in;

  // Next-state and register-load decisions.
  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (up_fire) begin
          state_next = BUSY;
          load_main  = 1'b1;
        end
      end
      BUSY: begin
        if (up_fire && down_fire) begin
          load_main = 1'b1;
        end else if (up_fire) begin
          // Downstream stalled: the new beat waits behind main_reg.
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (down_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // ready_up is 0 here, so only the drain of main_reg can happen.
        if (down_fire) begin
          state_next     = BUSY;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // State register; reset overrides every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: main_reg feeds data_out, skid_reg holds overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (load_main) begin
        main_reg <= main_from_skid ? skid_reg : bus.data_in;
      end
      if (load_skid) begin
        skid_reg <= bus.data_in;
      end
    end
  end

  assign bus.data_out       = main_reg;
  assign bus.valid_down_out = valid_down;
  assign bus.ready_up_out   = ready_up;
  assign bus.occupancy      = occ;
  assign state_dbg          = state;

endmodule

// File: tb/tb_skid_buffer.sv
// Directed bench for skid_buffer: one task per scenario, inline checks,
// single summary line at the end.
module tb_skid_buffer;
  import handshake_pkg::*;

  localparam int W = 32;

  logic        clk;
  logic        rst;
  skid_state_t state_dbg;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];

  skid_buffer_if #(.WIDTH(W)) bus ();

  skid_buffer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.valid_up_in   = 1'b1;
    bus.data_in       = 32'hDEAD;
    bus.ready_down_in = 1'b0;
    tick();
    checks++;
    if (bus.ready_up_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_during got %0b exp 1", bus.ready_up_out);
    end
    tick();
    rst = 1'b0;
    bus.valid_up_in = 1'b0;
    checks++;
    if (bus.valid_down_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %0b exp 0", bus.valid_down_out);
    end
    checks++;
    if (bus.ready_up_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %0b exp 1", bus.ready_up_out);
    end
    checks++;
    if (bus.occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_occ got %0d exp 0", bus.occupancy);
    end
    checks++;
    if (bus.data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", bus.data_out);
    end
    tick();
    checks++;
    if (bus.occupancy !== 2'd0 || bus.valid_down_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_nothing_accepted occ %0d valid %0b exp 0 0",
               bus.occupancy, bus.valid_down_out);
    end
  endtask

  task automatic test_streaming();
    bus.ready_down_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.valid_up_in = 1'b1;
      bus.data_in     = W'(i);
      tick();
      checks++;
      if (bus.data_out !== W'(i) || bus.valid_down_out !== 1'b1) begin
        errors++;
        $display("FAIL stream_data beat %0d got %h/%0b exp %h/1",
                 i, bus.data_out, bus.valid_down_out, W'(i));
      end
      checks++;
      if (bus.occupancy !== 2'd1 || bus.ready_up_out !== 1'b1) begin
        errors++;
        $display("FAIL stream_occ beat %0d occ %0d ready %0b exp 1 1",
                 i, bus.occupancy, bus.ready_up_out);
      end
    end
    bus.valid_up_in = 1'b0;
    tick();
    checks++;
    if (bus.occupancy !== 2'd0 || bus.valid_down_out !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain occ %0d valid %0b exp 0 0",
               bus.occupancy, bus.valid_down_out);
    end
  endtask

  task automatic test_stall_absorb();
    bus.ready_down_in = 1'b0;
    bus.valid_up_in   = 1'b1;
    bus.data_in       = 32'h11;
    tick();
    checks++;
    if (bus.occupancy !== 2'd1 || bus.data_out !== 32'h11) begin
      errors++;
      $display("FAIL stall_first occ %0d data %h exp 1 11", bus.occupancy, bus.data_out);
    end
    bus.data_in = 32'h22;
    tick();
    checks++;
    if (bus.occupancy !== 2'd2 || bus.ready_up_out !== 1'b0 || bus.data_out !== 32'h11) begin
      errors++;
      $display("FAIL stall_full occ %0d ready %0b data %h exp 2 0 11",
               bus.occupancy, bus.ready_up_out, bus.data_out);
    end
    // Offer a beat while FULL; it must be ignored.
    bus.data_in = 32'h33;
    tick();
    checks++;
    if (bus.occupancy !== 2'd2 || bus.data_out !== 32'h11 || bus.valid_down_out !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold occ %0d data %h valid %0b exp 2 11 1",
               bus.occupancy, bus.data_out, bus.valid_down_out);
    end
    bus.valid_up_in   = 1'b0;
    bus.ready_down_in = 1'b1;
    tick();
    checks++;
    if (bus.occupancy !== 2'd1 || bus.data_out !== 32'h22) begin
      errors++;
      $display("FAIL stall_second occ %0d data %h exp 1 22", bus.occupancy, bus.data_out);
    end
    tick();
    checks++;
    if (bus.occupancy !== 2'd0 || bus.valid_down_out !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty occ %0d valid %0b exp 0 0",
               bus.occupancy, bus.valid_down_out);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] payload;
    logic [W-1:0] head;
    int  accepted;
    int  delivered;
    int  cycles;
    int  bad;
    bit  up;
    bit  down;
    payload   = '0;
    accepted  = 0;
    delivered = 0;
    cycles    = 0;
    bad       = 0;
    exp_q.delete();
    while ((accepted < 2000 || exp_q.size() != 0) && cycles < 20000) begin
      if (accepted < 2000) begin
        bus.valid_up_in = 1'($urandom_range(0, 1));
      end else begin
        bus.valid_up_in = 1'b0;
      end
      bus.data_in       = payload;
      bus.ready_down_in = (accepted < 2000) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      checks++;
      if (bus.occupancy !== OCC_W'(exp_q.size()) ||
          bus.ready_up_out !== (exp_q.size() != 2) ||
          bus.valid_down_out !== (exp_q.size() != 0)) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL rand_ctrl cycle %0d occ %0d ready %0b valid %0b exp occ %0d",
                   cycles, bus.occupancy, bus.ready_up_out, bus.valid_down_out, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        checks++;
        if (bus.data_out !== head) begin
          errors++;
          bad++;
          if (bad <= 5)
            $display("FAIL rand_data cycle %0d got %h exp %h", cycles, bus.data_out, head);
        end
      end
      up   = bus.valid_up_in && (exp_q.size() != 2);
      down = bus.ready_down_in && (exp_q.size() != 0);
      if (down) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (up) begin
        exp_q.push_back(payload);
        payload++;
        accepted++;
      end
      tick();
      cycles++;
    end
    bus.valid_up_in = 1'b0;
    checks++;
    if (delivered != 2000 || accepted != 2000) begin
      errors++;
      $display("FAIL rand_count delivered %0d accepted %0d exp 2000 2000 (cycle budget)",
               delivered, accepted);
    end
    checks++;
    if (bus.occupancy !== 2'd0) begin
      errors++;
      $display("FAIL rand_final_occ got %0d exp 0", bus.occupancy);
    end
  endtask

  task automatic test_reset_mid_full();
    bus.ready_down_in = 1'b0;
    bus.valid_up_in   = 1'b1;
    bus.data_in       = 32'hAA;
    tick();
    bus.data_in = 32'hBB;
    tick();
    checks++;
    if (bus.occupancy !== 2'd2) begin
      errors++;
      $display("FAIL rstfull_pre occ %0d exp 2", bus.occupancy);
    end
    rst = 1'b1;
    bus.valid_up_in = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.valid_down_out !== 1'b0 || bus.occupancy !== 2'd0 || bus.data_out !== 32'h0) begin
      errors++;
      $display("FAIL rstfull_post valid %0b occ %0d data %h exp 0 0 0",
               bus.valid_down_out, bus.occupancy, bus.data_out);
    end
    bus.valid_up_in = 1'b1;
    bus.data_in     = 32'h55;
    tick();
    bus.valid_up_in = 1'b0;
    checks++;
    if (bus.data_out !== 32'h55 || bus.valid_down_out !== 1'b1 || bus.occupancy !== 2'd1) begin
      errors++;
      $display("FAIL rstfull_beat data %h valid %0b occ %0d exp 55 1 1",
               bus.data_out, bus.valid_down_out, bus.occupancy);
    end
    bus.ready_down_in = 1'b1;
    tick();
    checks++;
    if (bus.valid_down_out !== 1'b0 || bus.occupancy !== 2'd0) begin
      errors++;
      $display("FAIL rstfull_alone valid %0b occ %0d exp 0 0",
               bus.valid_down_out, bus.occupancy);
    end
  endtask

  task automatic test_simultaneous();
    bus.ready_down_in = 1'b0;
    bus.valid_up_in   = 1'b1;
    bus.data_in       = 32'h66;
    tick();
    checks++;
    if (bus.data_out !== 32'h66 || bus.occupancy !== 2'd1) begin
      errors++;
      $display("FAIL simul_pre data %h occ %0d exp 66 1", bus.data_out, bus.occupancy);
    end
    bus.data_in       = 32'h77;
    bus.ready_down_in = 1'b1;
    tick();
    bus.valid_up_in = 1'b0;
    checks++;
    if (bus.data_out !== 32'h77 || bus.occupancy !== 2'd1 || state_dbg !== BUSY) begin
      errors++;
      $display("FAIL simul_busy data %h occ %0d state %0d exp 77 1 1",
               bus.data_out, bus.occupancy, state_dbg);
    end
    tick();
    checks++;
    if (bus.occupancy !== 2'd0) begin
      errors++;
      $display("FAIL simul_drain occ %0d exp 0", bus.occupancy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.data_in       = '0;
    bus.valid_up_in   = 1'b0;
    bus.ready_down_in = 1'b0;
    #1;
    test_reset();
    test_streaming();
    test_stall_absorb();
    test_random();
    test_reset_mid_full();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
